video_frame_stats: RTL and testbench

VIDEO_FRAME_STATS -- requirements
Module: video_frame_stats

---
 rtl/video_frame_stats.sv | 212 +++++++++++++++++++++
 tb/tb_video_frame_stats.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_frame_stats.sv
// Per-frame video statistics: active pixel/line counts, RGB sums and
// luma extremes, reported through a valid/ready port with drop tracking.
module video_frame_stats #(
    parameter int PIX_W  = 24,
    parameter int LINE_W = 12
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic              iPixelSync,
    input  logic              iPixelStrobe,
    input  logic              iPixelActive,
    input  logic [7:0]        iDataRed,
    input  logic [7:0]        iDataGreen,
    input  logic [7:0]        iDataBlue,
    output logic              oStatsValid,
    input  logic              iStatsReady,
    output logic [PIX_W-1:0]  oPixelCount,
    output logic [LINE_W-1:0] oLineCount,
    output logic [31:0]       oSumRed,
    output logic [31:0]       oSumGreen,
    output logic [31:0]       oSumBlue,
    output logic [7:0]        oMinLuma,
    output logic [7:0]        oMaxLuma,
    output logic [15:0]       oFrameCount,
    output logic [7:0]        oDropCount
);

    typedef enum logic {
        WAIT_SYNC,
        ACCUM
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              w_open;
    logic              w_close;
    logic              w_live;
    logic              w_qual;
    logic              w_take;
    logic              w_prev;
    logic              w_line_inc;
    logic              w_hold;
    logic              w_load;
    logic              w_drop;
    logic [10:0]       w_luma_sum;
    logic [7:0]        w_luma;

    logic [PIX_W-1:0]  r_pix;
    logic [LINE_W-1:0] r_lines;
    logic [31:0]       r_sum_r;
    logic [31:0]       r_sum_g;
    logic [31:0]       r_sum_b;
    logic [7:0]        r_min;
    logic [7:0]        r_max;
    logic              r_prev_act;
    logic [15:0]       r_frame_idx;

    logic [PIX_W-1:0]  w_pix_base;
    logic [LINE_W-1:0] w_line_base;
    logic [31:0]       w_sum_r_base;
    logic [31:0]       w_sum_g_base;
    logic [31:0]       w_sum_b_base;
    logic [7:0]        w_min_base;
    logic [7:0]        w_max_base;

    logic              r_valid;
    logic [PIX_W-1:0]  r_o_pix;
    logic [LINE_W-1:0] r_o_lines;
    logic [31:0]       r_o_sum_r;
    logic [31:0]       r_o_sum_g;
    logic [31:0]       r_o_sum_b;
    logic [7:0]        r_o_min;
    logic [7:0]        r_o_max;
    logic [15:0]       r_o_frame;
    logic [7:0]        r_drop;

    assign w_qual     = iPixelStrobe & iPixelActive;
    assign w_luma_sum = {2'b00, iDataRed, 1'b0}
                      + {1'b0, iDataGreen, 2'b00}
                      + {3'b000, iDataGreen}
                      + {3'b000, iDataBlue};
    assign w_luma     = w_luma_sum[10:3];

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_state <= WAIT_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_open      = 1'b0;
        w_close     = 1'b0;
        unique case (r_state)
            WAIT_SYNC: begin
                if (iPixelSync) begin
                    w_state_nxt = ACCUM;
                    w_open      = 1'b1;
                end
            end
            ACCUM: begin
                if (iPixelSync) begin
                    w_open  = 1'b1;
                    w_close = 1'b1;
                end
            end
        endcase
    end

    // A sync reloads the accumulators; the same-cycle pixel then lands
    // on the freshly reloaded values, i.e. in the new frame.
    assign w_live       = (r_state == ACCUM) || w_open;
    assign w_pix_base   = w_open ? '0 : r_pix;
    assign w_line_base  = w_open ? '0 : r_lines;
    assign w_sum_r_base = w_open ? 32'd0 : r_sum_r;
    assign w_sum_g_base = w_open ? 32'd0 : r_sum_g;
    assign w_sum_b_base = w_open ? 32'd0 : r_sum_b;
    assign w_min_base   = w_open ? 8'hFF : r_min;
    assign w_max_base   = w_open ? 8'h00 : r_max;
    assign w_prev       = w_open ? 1'b0 : r_prev_act;

    assign w_take     = w_live && w_qual && !(&w_pix_base);
    assign w_line_inc = w_live && w_qual && !w_prev && !(&w_line_base);

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_pix      <= '0;
            r_lines    <= '0;
            r_sum_r    <= 32'd0;
            r_sum_g    <= 32'd0;
            r_sum_b    <= 32'd0;
            r_min      <= 8'hFF;
            r_max      <= 8'h00;
            r_prev_act <= 1'b0;
        end else begin
            r_pix   <= w_take ? w_pix_base + 1'b1 : w_pix_base;
            r_lines <= w_line_inc ? w_line_base + 1'b1 : w_line_base;
            r_sum_r <= w_take ? w_sum_r_base + {24'd0, iDataRed}
                              : w_sum_r_base;
            r_sum_g <= w_take ? w_sum_g_base + {24'd0, iDataGreen}
                              : w_sum_g_base;
            r_sum_b <= w_take ? w_sum_b_base + {24'd0, iDataBlue}
                              : w_sum_b_base;
            r_min   <= (w_take && (w_luma < w_min_base)) ? w_luma
                                                         : w_min_base;
            r_max   <= (w_take && (w_luma > w_max_base)) ? w_luma
                                                         : w_max_base;
            if (!w_live) begin
                r_prev_act <= 1'b0;
            end else if (iPixelStrobe) begin
                r_prev_act <= iPixelActive;
            end else begin
                r_prev_act <= w_prev;
            end
        end
    end

    assign w_hold = r_valid && !iStatsReady;
    assign w_load = w_close && !w_hold;
    assign w_drop = w_close && w_hold;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_valid     <= 1'b0;
            r_o_pix     <= '0;
            r_o_lines   <= '0;
            r_o_sum_r   <= 32'd0;
            r_o_sum_g   <= 32'd0;
            r_o_sum_b   <= 32'd0;
            r_o_min     <= 8'hFF;
            r_o_max     <= 8'h00;
            r_o_frame   <= 16'd0;
            r_frame_idx <= 16'd0;
            r_drop      <= 8'd0;
        end else begin
            if (w_close) begin
                r_frame_idx <= r_frame_idx + 16'd1;
            end
            if (w_load) begin
                r_valid   <= 1'b1;
                r_o_pix   <= r_pix;
                r_o_lines <= r_lines;
                r_o_sum_r <= r_sum_r;
                r_o_sum_g <= r_sum_g;
                r_o_sum_b <= r_sum_b;
                r_o_min   <= r_min;
                r_o_max   <= r_max;
                r_o_frame <= r_frame_idx;
            end else if (r_valid && iStatsReady) begin
                r_valid <= 1'b0;
            end
            if (w_drop && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    assign oStatsValid = r_valid;
    assign oPixelCount = r_o_pix;
    assign oLineCount  = r_o_lines;
    assign oSumRed     = r_o_sum_r;
    assign oSumGreen   = r_o_sum_g;
    assign oSumBlue    = r_o_sum_b;
    assign oMinLuma    = r_o_min;
    assign oMaxLuma    = r_o_max;
    assign oFrameCount = r_o_frame;
    assign oDropCount  = r_drop;

endmodule

// File: tb/tb_video_frame_stats.sv
// Directed bench for video_frame_stats, built with narrow counters so
// pixel and line saturation are reachable in a few cycles.
module tb_video_frame_stats;

    localparam int PIX_W  = 4;
    localparam int LINE_W = 2;

    logic              iClk = 1'b0;
    logic              iRstN;
    logic              iPixelSync;
    logic              iPixelStrobe;
    logic              iPixelActive;
    logic [7:0]        iDataRed;
    logic [7:0]        iDataGreen;
    logic [7:0]        iDataBlue;
    logic              oStatsValid;
    logic              iStatsReady;
    logic [PIX_W-1:0]  oPixelCount;
    logic [LINE_W-1:0] oLineCount;
    logic [31:0]       oSumRed;
    logic [31:0]       oSumGreen;
    logic [31:0]       oSumBlue;
    logic [7:0]        oMinLuma;
    logic [7:0]        oMaxLuma;
    logic [15:0]       oFrameCount;
    logic [7:0]        oDropCount;

    int n_pass  = 0;
    int n_total = 0;

    video_frame_stats #(
        .PIX_W (PIX_W),
        .LINE_W(LINE_W)
    ) dut (
        .iClk        (iClk),
        .iRstN       (iRstN),
        .iPixelSync  (iPixelSync),
        .iPixelStrobe(iPixelStrobe),
        .iPixelActive(iPixelActive),
        .iDataRed    (iDataRed),
        .iDataGreen  (iDataGreen),
        .iDataBlue   (iDataBlue),
        .oStatsValid (oStatsValid),
        .iStatsReady (iStatsReady),
        .oPixelCount (oPixelCount),
        .oLineCount  (oLineCount),
        .oSumRed     (oSumRed),
        .oSumGreen   (oSumGreen),
        .oSumBlue    (oSumBlue),
        .oMinLuma    (oMinLuma),
        .oMaxLuma    (oMaxLuma),
        .oFrameCount (oFrameCount),
        .oDropCount  (oDropCount)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input logic s, input logic st, input logic ac,
                        input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b);
        iPixelSync   = s;
        iPixelStrobe = st;
        iPixelActive = ac;
        iDataRed     = r;
        iDataGreen   = g;
        iDataBlue    = b;
        @(posedge iClk);
        #1;
    endtask

    task automatic pix(input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b);
        step(1'b0, 1'b1, 1'b1, r, g, b);
    endtask

    task automatic blank();
        step(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic sync();
        step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic chk_res(input string tag, input logic v,
                           input logic [31:0] p, input logic [31:0] l,
                           input logic [31:0] sr, input logic [31:0] sg,
                           input logic [31:0] sb, input logic [7:0] mn,
                           input logic [7:0] mx, input logic [15:0] fc);
        chk({tag, ".valid"}, {31'd0, oStatsValid}, {31'd0, v});
        chk({tag, ".pix"}, {28'd0, oPixelCount}, p);
        chk({tag, ".lines"}, {30'd0, oLineCount}, l);
        chk({tag, ".sumr"}, oSumRed, sr);
        chk({tag, ".sumg"}, oSumGreen, sg);
        chk({tag, ".sumb"}, oSumBlue, sb);
        chk({tag, ".min"}, {24'd0, oMinLuma}, {24'd0, mn});
        chk({tag, ".max"}, {24'd0, oMaxLuma}, {24'd0, mx});
        chk({tag, ".frame"}, {16'd0, oFrameCount}, {16'd0, fc});
    endtask

    initial begin
        iRstN       = 1'b0;
        iStatsReady = 1'b1;
        idle();
        idle();
        chk_res("reset", 1'b0, 0, 0, 0, 0, 0, 8'hFF, 8'h00, 16'd0);
        chk("reset.drop", {24'd0, oDropCount}, 32'd0);
        iRstN = 1'b1;
        idle();

        // frame 0: 4x3 block of 0x10 grey with blanking between lines
        sync();
        chk("open.valid", {31'd0, oStatsValid}, 32'd0);
        for (int ln = 0; ln < 3; ln++) begin
            for (int px = 0; px < 4; px++) pix(8'h10, 8'h10, 8'h10);
            blank();
            blank();
        end
        sync();
        chk_res("f0", 1'b1, 12, 3, 32'hC0, 32'hC0, 32'hC0,
                8'h10, 8'h10, 16'd0);
        idle();
        chk("f0.drop_valid", {31'd0, oStatsValid}, 32'd0);

        // frame 1: strobe on alternate cycles, active held high
        pix(8'h08, 8'h08, 8'h08);
        step(1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF);
        pix(8'h40, 8'h40, 8'h40);
        step(1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF);
        pix(8'h00, 8'h20, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF);
        pix(8'h80, 8'h00, 8'h10);
        step(1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF);
        blank();
        sync();
        chk_res("f1", 1'b1, 4, 1, 32'hC8, 32'h68, 32'h58,
                8'h08, 8'h40, 16'd1);

        // frame 2 closes with a qualified red pixel that belongs to frame 3
        pix(8'h01, 8'h02, 8'h03);
        pix(8'h01, 8'h02, 8'h03);
        step(1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 8'h00);
        chk_res("f2", 1'b1, 2, 1, 32'h2, 32'h4, 32'h6,
                8'h01, 8'h01, 16'd2);
        blank();
        chk("f2.drop_valid", {31'd0, oStatsValid}, 32'd0);
        sync();
        chk_res("f3", 1'b1, 1, 1, 32'hFF, 32'h0, 32'h0,
                8'h3F, 8'h3F, 16'd3);

        // back-pressure: frames 4 and 5 close while frame 3 is held
        iStatsReady = 1'b0;
        pix(8'h20, 8'h20, 8'h20);
        pix(8'h20, 8'h20, 8'h20);
        sync();
        chk_res("hold1", 1'b1, 1, 1, 32'hFF, 32'h0, 32'h0,
                8'h3F, 8'h3F, 16'd3);
        chk("hold1.drop", {24'd0, oDropCount}, 32'd1);
        sync();
        chk_res("hold2", 1'b1, 1, 1, 32'hFF, 32'h0, 32'h0,
                8'h3F, 8'h3F, 16'd3);
        chk("hold2.drop", {24'd0, oDropCount}, 32'd2);
        iStatsReady = 1'b1;
        sync();
        chk_res("f6_empty", 1'b1, 0, 0, 32'h0, 32'h0, 32'h0,
                8'hFF, 8'h00, 16'd6);
        chk("f6.drop", {24'd0, oDropCount}, 32'd2);
        idle();
        chk("f6.drop_valid", {31'd0, oStatsValid}, 32'd0);

        // frame 7: pixel counter saturates at 15, lines at 3
        for (int ln = 0; ln < 5; ln++) begin
            for (int px = 0; px < 3; px++) pix(8'h10, 8'h10, 8'h10);
            blank();
        end
        for (int px = 0; px < 3; px++) pix(8'hFF, 8'hFF, 8'hFF);
        blank();
        sync();
        chk_res("f7_sat", 1'b1, 15, 3, 32'hF0, 32'hF0, 32'hF0,
                8'h10, 8'h10, 16'd7);

        // reset mid-frame discards everything
        pix(8'h10, 8'h10, 8'h10);
        iRstN = 1'b0;
        #1;
        chk_res("midrst", 1'b0, 0, 0, 0, 0, 0, 8'hFF, 8'h00, 16'd0);
        chk("midrst.drop", {24'd0, oDropCount}, 32'd0);
        idle();
        iRstN = 1'b1;
        pix(8'h10, 8'h10, 8'h10);
        sync();
        chk("rst_open.valid", {31'd0, oStatsValid}, 32'd0);
        pix(8'h10, 8'h20, 8'h30);
        blank();
        sync();
        chk_res("post_rst", 1'b1, 1, 1, 32'h10, 32'h20, 32'h30,
                8'h1E, 8'h1E, 16'd0);

        // drop counter saturation
        iStatsReady = 1'b0;
        for (int i = 0; i < 260; i++) sync();
        chk("dropsat.drop", {24'd0, oDropCount}, 32'hFF);
        chk("dropsat.frame", {16'd0, oFrameCount}, 32'd0);
        chk("dropsat.valid", {31'd0, oStatsValid}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
